instruction_loader: RTL and testbench
=====================================

INSTRUCTION_LOADER -- requirements
Module: instruction_loader

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 13'h0000, meaning first byte address written (word-aligned; bits [1:0] ignored).
REQ-002 SHALL have port CLOCK, input, 1, single clock; all state changes on rising edge.
REQ-003 SHALL have port RESET, input, 1, asynchronous, active-high reset.
REQ-004 SHALL have port start, input, 1, one-cycle request to begin a load; honoured only in IDLE.
REQ-005 SHALL have port load_len, input, 11, number of 32-bit words to load; sampled when start is honoured.
REQ-006 SHALL have port abort, input, 1, terminate the load; priority over all non-reset events.
REQ-007 SHALL have port byte_in, input, 8, program byte stream.
REQ-008 SHALL have port byte_valid, input, 1, byte_in valid this cycle.
REQ-009 SHALL have port byte_ready, output, 1, loader accepts byte_in this cycle.
REQ-010 SHALL have port wr_en, output, 1, instruction-memory write strobe, one cycle per word.
REQ-011 SHALL have port wr_addr, output, 13, byte address of the word written (same width and byte addressing as PC).
REQ-012 SHALL have port wr_data, output, 32, assembled instruction word.
REQ-013 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-014 SHALL have port done, output, 1, one-cycle pulse on normal completion.
REQ-015 SHALL have port checksum, output, 32, modulo-2^32 sum of all words written in the current/last load.

Function
REQ-016 SHALL implement states IDLE, COLLECT, WRITE, DONE.
REQ-017 IDLE: start=1 with load_len!=0 -> COLLECT; address counter := BASE_ADDR with [1:0]=0, word counter := load_len, byte index := 0, checksum := 0.
REQ-018 IDLE: start=1 with load_len=0 -> DONE directly, no write, checksum := 0.
REQ-019 byte_ready SHALL be 1 only in COLLECT; a byte transfers when byte_valid & byte_ready.
REQ-020 Bytes SHALL assemble big-endian: 1st byte -> wr_data[31:24], 2nd -> [23:16], 3rd -> [15:8], 4th -> [7:0].
REQ-021 4th accepted byte -> WRITE next cycle; byte_valid low in COLLECT SHALL only stall, never lose state.
REQ-022 WRITE lasts exactly one cycle: wr_en=1, wr_addr=address counter, wr_data=assembled word; checksum += word at end of cycle.
REQ-023 After WRITE: address += 4 (13-bit wrap 13'h1FFC -> 13'h0000), word counter -= 1; counter reaching 0 -> DONE, else COLLECT with byte index 0.
REQ-024 Byte-to-write latency: 1 cycle after 4th byte handshake; min 5 cycles per word incl. WRITE.
REQ-025 DONE lasts one cycle with done=1, then IDLE; checksum holds until next honoured start.
REQ-026 start outside IDLE SHALL be ignored.
REQ-027 abort=1 in COLLECT or WRITE -> IDLE next cycle; a WRITE cycle coinciding with abort SHALL still assert wr_en (word committed, included in checksum); partial words discarded; done not asserted.
REQ-028 abort in IDLE or DONE SHALL have no effect (DONE still pulses done).
REQ-029 wr_en, byte_ready, done SHALL be 0 whenever not stated above; wr_addr/wr_data SHALL hold last value outside WRITE.

Reset
REQ-030 RESET=1 SHALL immediately force IDLE, wr_en=0, byte_ready=0, busy=0, done=0, wr_addr=0, wr_data=0, checksum=0, counters 0, regardless of clock.
REQ-031 RESET asserted mid-load SHALL discard the load; no further writes after release until a new start.

Verification
REQ-032 BASE_ADDR=0, start, load_len=2, bytes 20 08 00 05 8C 09 00 04 back-to-back -> writes (0x0000, 0x20080005), (0x0004, 0x8C090004); done pulse; checksum=0xAC110009.
REQ-033 load_len=1, byte_valid toggled 1/0 each cycle, bytes 00 00 00 0C -> single write (0x0000, 0x0000000C) only after 4th byte; no duplicate write.
REQ-034 BASE_ADDR=13'h1FFC, load_len=2, bytes FF FF FF FF 00 00 00 01 -> writes at 0x1FFC then 0x0000; checksum=0x00000000.
REQ-035 start with load_len=0 -> done one cycle later, busy high one cycle, no wr_en.
REQ-036 load_len=3, abort after 6 bytes -> exactly one write, IDLE next cycle, no done; start during load ignored.
REQ-037 RESET asserted mid-COLLECT between clock edges -> all outputs zero immediately; no write after release.

Source files
------------

// File: rtl/instruction_loader.sv
// ---------------------------------------------------------------------------
// instruction_loader
//
// Assembles a big-endian byte stream into 32-bit instruction words and writes
// them into instruction memory starting at BASE_ADDR. It also keeps a
// modulo-2^32 checksum of every word written in the current or last load.
//
// Parameters
//   BASE_ADDR  : byte address of the first word written (bits [1:0] ignored)
//
// Ports
//   CLOCK      : single clock, rising edge
//   RESET      : asynchronous, active-high reset
//   start      : one-cycle load request, honoured only while idle
//   load_len   : number of 32-bit words to load, sampled with start
//   abort      : terminates a load in progress
//   byte_in    : program byte stream
//   byte_valid : byte_in is valid this cycle
//   byte_ready : loader accepts byte_in this cycle
//   wr_en      : instruction-memory write strobe, one cycle per word
//   wr_addr    : byte address of the word being written
//   wr_data    : assembled instruction word
//   busy       : high whenever the loader is not idle
//   done       : one-cycle pulse on normal completion
//   checksum   : sum of all words written in the current/last load
// ---------------------------------------------------------------------------
module instruction_loader #(
    parameter logic [12:0] BASE_ADDR = 13'h0000
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic        start,
    input  logic [10:0] load_len,
    input  logic        abort,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic        wr_en,
    output logic [12:0] wr_addr,
    output logic [31:0] wr_data,
    output logic        busy,
    output logic        done,
    output logic [31:0] checksum
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        WRITE   = 2'd2,
        DONE    = 2'd3
    } state_t;

    // Word-aligned start address; the low two bits of BASE_ADDR are dropped.
    localparam logic [12:0] START_ADDR = {BASE_ADDR[12:2], 2'b00};

    state_t      state;
    state_t      state_nxt;

    logic [12:0] addr_cnt;
    logic [10:0] word_cnt;
    logic [1:0]  byte_idx;
    logic [31:0] word_acc;
    logic [12:0] wr_addr_q;
    logic [31:0] wr_data_q;
    logic [31:0] checksum_q;

    logic        byte_take;
    logic        last_byte;

    // Abort wins over a byte handshake: a byte arriving with abort belongs to
    // a word that is being discarded anyway.
    assign byte_take = (state == COLLECT) && byte_valid && !abort;
    assign last_byte = byte_take && (byte_idx == 2'd3);

    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign checksum = checksum_q;

    // ---------------------------------------------------------------------
    // State register
    // ---------------------------------------------------------------------
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---------------------------------------------------------------------
    // Next-state and control outputs
    // ---------------------------------------------------------------------
    always_comb begin
        state_nxt  = state;
        byte_ready = 1'b0;
        wr_en      = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;

        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nxt = (load_len == 11'd0) ? DONE : COLLECT;
                end
            end
            COLLECT: begin
                byte_ready = 1'b1;
                if (abort) begin
                    state_nxt = IDLE;
                end else if (last_byte) begin
                    state_nxt = WRITE;
                end
            end
            WRITE: begin
                // The word is committed even when abort arrives this cycle.
                wr_en = 1'b1;
                if (abort) begin
                    state_nxt = IDLE;
                end else if (word_cnt == 11'd1) begin
                    state_nxt = DONE;
                end else begin
                    state_nxt = COLLECT;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Counters, word assembly, write registers and checksum
    // ---------------------------------------------------------------------
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            addr_cnt   <= 13'd0;
            word_cnt   <= 11'd0;
            byte_idx   <= 2'd0;
            word_acc   <= 32'd0;
            wr_addr_q  <= 13'd0;
            wr_data_q  <= 32'd0;
            checksum_q <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        addr_cnt   <= START_ADDR;
                        word_cnt   <= load_len;
                        byte_idx   <= 2'd0;
                        checksum_q <= 32'd0;
                    end
                end
                COLLECT: begin
                    if (byte_take) begin
                        // Shifting left leaves the first byte in [31:24].
                        word_acc <= {word_acc[23:0], byte_in};
                        byte_idx <= byte_idx + 2'd1;
                    end
                    // Write registers load only here so they hold their
                    // value everywhere outside WRITE.
                    if (last_byte) begin
                        wr_addr_q <= addr_cnt;
                        wr_data_q <= {word_acc[23:0], byte_in};
                    end
                end
                WRITE: begin
                    checksum_q <= checksum_q + wr_data_q;
                    addr_cnt   <= addr_cnt + 13'd4;
                    word_cnt   <= word_cnt - 11'd1;
                    byte_idx   <= 2'd0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_loader.sv
module tb_instruction_loader;

    logic        CLOCK = 1'b0;
    logic        RESET = 1'b0;
    logic        start = 1'b0;
    logic [10:0] load_len = 11'd0;
    logic        abort = 1'b0;
    logic [7:0]  byte_in = 8'd0;
    logic        byte_valid = 1'b0;

    logic        byte_ready0, wr_en0, busy0, done0;
    logic [12:0] wr_addr0;
    logic [31:0] wr_data0, checksum0;
    logic        byte_ready1, wr_en1, busy1, done1;
    logic [12:0] wr_addr1;
    logic [31:0] wr_data1, checksum1;

    int checks = 0;
    int errors = 0;
    int done_cnt0 = 0;
    logic [44:0] wq0[$];
    logic [44:0] wq1[$];

    instruction_loader #(.BASE_ADDR(13'h0000)) dut0 (
        .CLOCK(CLOCK), .RESET(RESET), .start(start), .load_len(load_len),
        .abort(abort), .byte_in(byte_in), .byte_valid(byte_valid),
        .byte_ready(byte_ready0), .wr_en(wr_en0), .wr_addr(wr_addr0),
        .wr_data(wr_data0), .busy(busy0), .done(done0), .checksum(checksum0)
    );

    instruction_loader #(.BASE_ADDR(13'h1FFC)) dut1 (
        .CLOCK(CLOCK), .RESET(RESET), .start(start), .load_len(load_len),
        .abort(abort), .byte_in(byte_in), .byte_valid(byte_valid),
        .byte_ready(byte_ready1), .wr_en(wr_en1), .wr_addr(wr_addr1),
        .wr_data(wr_data1), .busy(busy1), .done(done1), .checksum(checksum1)
    );

    always #5 CLOCK = ~CLOCK;

    // Record every write and done pulse, sampled on the falling edge.
    always @(negedge CLOCK) begin
        if (wr_en0 === 1'b1) wq0.push_back({wr_addr0, wr_data0});
        if (wr_en1 === 1'b1) wq1.push_back({wr_addr1, wr_data1});
        if (done0 === 1'b1) done_cnt0 = done_cnt0 + 1;
    end

    task automatic step();
        @(posedge CLOCK);
        #1;
    endtask

    // Present one byte and hold it until the loader has taken it.
    task automatic send_byte(input logic [7:0] b);
        logic rdy;
        int   n;
        byte_valid = 1'b1;
        byte_in    = b;
        n          = 0;
        do begin
            rdy = byte_ready0;
            step();
            n++;
        end while (!rdy && n < 20);
        byte_valid = 1'b0;
        checks++;
        if (!rdy) begin
            errors++;
            $display("FAIL byte_handshake: byte %h not accepted within %0d cycles", b, n);
        end
    endtask

    task automatic test_reset();
        #1 RESET = 1'b1;
        #1;
        checks++;
        if ({busy0, byte_ready0, wr_en0, done0} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctrl: got %b required 0000", {busy0, byte_ready0, wr_en0, done0});
        end
        checks++;
        if ({wr_addr0, wr_data0, checksum0} !== 77'd0) begin
            errors++;
            $display("FAIL reset_data: got %h %h %h required zeros", wr_addr0, wr_data0, checksum0);
        end
        step();
        step();
        RESET = 1'b0;
        step();
    endtask

    task automatic test_basic_load();
        int b;
        b = wq0.size();
        start = 1'b1; load_len = 11'd2;
        step();
        start = 1'b0;
        send_byte(8'h20); send_byte(8'h08); send_byte(8'h00); send_byte(8'h05);
        checks++;
        if ({wr_en0, wr_addr0, wr_data0} !== {1'b1, 13'h0000, 32'h20080005}) begin
            errors++;
            $display("FAIL basic_write0: got en=%b %h %h required en=1 0000 20080005", wr_en0, wr_addr0, wr_data0);
        end
        send_byte(8'h8C); send_byte(8'h09); send_byte(8'h00); send_byte(8'h04);
        checks++;
        if ({wr_en0, wr_addr0, wr_data0} !== {1'b1, 13'h0004, 32'h8C090004}) begin
            errors++;
            $display("FAIL basic_write1: got en=%b %h %h required en=1 0004 8C090004", wr_en0, wr_addr0, wr_data0);
        end
        step();
        checks++;
        if (done0 !== 1'b1) begin
            errors++;
            $display("FAIL basic_done: got %b required 1", done0);
        end
        step();
        checks++;
        if ({busy0, done0} !== 2'b00) begin
            errors++;
            $display("FAIL basic_idle: busy/done got %b required 00", {busy0, done0});
        end
        checks++;
        if (checksum0 !== 32'hAC110009) begin
            errors++;
            $display("FAIL basic_checksum: got %h required AC110009", checksum0);
        end
        checks++;
        if (wq0.size() - b !== 2) begin
            errors++;
            $display("FAIL basic_count: got %0d writes required 2", wq0.size() - b);
        end
    endtask

    task automatic test_stall();
        int b;
        logic [7:0] bytes [4];
        bytes = '{8'h00, 8'h00, 8'h00, 8'h0C};
        b = wq0.size();
        start = 1'b1; load_len = 11'd1;
        step();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            byte_valid = 1'b0;
            step();
            send_byte(bytes[i]);
            if (i == 2) begin
                checks++;
                if (wq0.size() !== b) begin
                    errors++;
                    $display("FAIL stall_early: got %0d writes required 0 after 3 bytes", wq0.size() - b);
                end
            end
        end
        step(); step(); step();
        checks++;
        if (wq0.size() - b !== 1) begin
            errors++;
            $display("FAIL stall_count: got %0d writes required 1", wq0.size() - b);
        end
        checks++;
        if (wq0[b] !== {13'h0000, 32'h0000000C}) begin
            errors++;
            $display("FAIL stall_word: got %h required %h", wq0[b], {13'h0000, 32'h0000000C});
        end
        checks++;
        if (checksum0 !== 32'h0000000C) begin
            errors++;
            $display("FAIL stall_checksum: got %h required 0000000C", checksum0);
        end
    endtask

    task automatic test_addr_wrap();
        int b;
        b = wq1.size();
        start = 1'b1; load_len = 11'd2;
        step();
        start = 1'b0;
        send_byte(8'hFF); send_byte(8'hFF); send_byte(8'hFF); send_byte(8'hFF);
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h01);
        step(); step();
        checks++;
        if (wq1[b] !== {13'h1FFC, 32'hFFFFFFFF}) begin
            errors++;
            $display("FAIL wrap_write0: got %h required %h", wq1[b], {13'h1FFC, 32'hFFFFFFFF});
        end
        checks++;
        if (wq1[b+1] !== {13'h0000, 32'h00000001}) begin
            errors++;
            $display("FAIL wrap_write1: got %h required %h", wq1[b+1], {13'h0000, 32'h00000001});
        end
        checks++;
        if (checksum1 !== 32'h00000000) begin
            errors++;
            $display("FAIL wrap_checksum: got %h required 00000000", checksum1);
        end
    endtask

    task automatic test_zero_len();
        int b;
        b = wq0.size();
        start = 1'b1; load_len = 11'd0;
        step();
        start = 1'b0;
        checks++;
        if ({done0, busy0, wr_en0} !== 3'b110) begin
            errors++;
            $display("FAIL zero_done: done/busy/wr_en got %b required 110", {done0, busy0, wr_en0});
        end
        step();
        checks++;
        if ({done0, busy0} !== 2'b00) begin
            errors++;
            $display("FAIL zero_idle: done/busy got %b required 00", {done0, busy0});
        end
        checks++;
        if (wq0.size() !== b || checksum0 !== 32'd0) begin
            errors++;
            $display("FAIL zero_nowrite: got %0d writes checksum %h required 0 writes 00000000", wq0.size() - b, checksum0);
        end
    endtask

    task automatic test_abort_collect();
        int b, d;
        b = wq0.size();
        d = done_cnt0;
        start = 1'b1; load_len = 11'd3;
        step();
        start = 1'b0;
        send_byte(8'h01); send_byte(8'h02);
        start = 1'b1; load_len = 11'd5;
        send_byte(8'h03);
        start = 1'b0;
        send_byte(8'h04); send_byte(8'h05); send_byte(8'h06);
        abort = 1'b1;
        step();
        abort = 1'b0;
        checks++;
        if (busy0 !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle: busy got %b required 0", busy0);
        end
        step(); step();
        checks++;
        if (wq0.size() - b !== 1 || wq0[b] !== {13'h0000, 32'h01020304}) begin
            errors++;
            $display("FAIL abort_writes: got %0d writes first %h required 1 write %h", wq0.size() - b, wq0[b], {13'h0000, 32'h01020304});
        end
        checks++;
        if (done_cnt0 !== d) begin
            errors++;
            $display("FAIL abort_nodone: got %0d done pulses required 0", done_cnt0 - d);
        end
        checks++;
        if (checksum0 !== 32'h01020304) begin
            errors++;
            $display("FAIL abort_checksum: got %h required 01020304", checksum0);
        end
    endtask

    task automatic test_abort_write();
        int b, d;
        b = wq0.size();
        d = done_cnt0;
        start = 1'b1; load_len = 11'd2;
        step();
        start = 1'b0;
        send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
        abort = 1'b1;
        #1;
        checks++;
        if (wr_en0 !== 1'b1) begin
            errors++;
            $display("FAIL abortw_wren: got %b required 1", wr_en0);
        end
        step();
        abort = 1'b0;
        checks++;
        if (busy0 !== 1'b0) begin
            errors++;
            $display("FAIL abortw_idle: busy got %b required 0", busy0);
        end
        step();
        checks++;
        if (wq0.size() - b !== 1 || checksum0 !== 32'hAABBCCDD || done_cnt0 !== d) begin
            errors++;
            $display("FAIL abortw_result: writes %0d checksum %h done %0d required 1 AABBCCDD 0", wq0.size() - b, checksum0, done_cnt0 - d);
        end
    endtask

    task automatic test_reset_mid_load();
        int b;
        b = wq0.size();
        start = 1'b1; load_len = 11'd2;
        step();
        start = 1'b0;
        send_byte(8'h11); send_byte(8'h22);
        #2 RESET = 1'b1;
        #1;
        checks++;
        if ({busy0, byte_ready0, wr_en0, done0} !== 4'b0000) begin
            errors++;
            $display("FAIL rstmid_ctrl: got %b required 0000", {busy0, byte_ready0, wr_en0, done0});
        end
        checks++;
        if ({wr_addr0, wr_data0, checksum0} !== 77'd0) begin
            errors++;
            $display("FAIL rstmid_data: got %h %h %h required zeros", wr_addr0, wr_data0, checksum0);
        end
        #3 RESET = 1'b0;
        byte_valid = 1'b1;
        byte_in    = 8'h33;
        for (int i = 0; i < 8; i++) step();
        byte_valid = 1'b0;
        checks++;
        if (wq0.size() !== b || busy0 !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_nowrite: got %0d writes busy %b required 0 writes busy 0", wq0.size() - b, busy0);
        end
    endtask

    initial begin
        test_reset();
        test_basic_load();
        test_stall();
        test_addr_wrap();
        test_zero_len();
        test_abort_collect();
        test_abort_write();
        test_reset_mid_load();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
